pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the pipeline stages / divider and pipe_ctrl.
//   master : pipeline side; drives stall/flush/divide requests, receives
//            stall vector, flush target and divider control.
//   slave  : pipe_ctrl itself.
interface pipe_ctrl_if;
  logic        id_stallreq_i;
  logic        ex_stallreq_i;
  logic        ex_div_req_i;
  logic        ex_div_signed_i;
  logic        div_ready_i;
  logic        mem_stallreq_i;
  logic        flush_req_i;
  logic [31:0] new_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_start_o;
  logic        div_signed_o;
  logic        div_annul_o;
  logic        div_timeout_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output id_stallreq_i, ex_stallreq_i, ex_div_req_i, ex_div_signed_i,
           div_ready_i, mem_stallreq_i, flush_req_i, new_pc_i,
    input  stall_o, flush_o, new_pc_o, div_start_o, div_signed_o,
           div_annul_o, div_timeout_o, stall_cycles_o
  );

  modport slave (
    input  id_stallreq_i, ex_stallreq_i, ex_div_req_i, ex_div_signed_i,
           div_ready_i, mem_stallreq_i, flush_req_i, new_pc_i,
    output stall_o, flush_o, new_pc_o, div_start_o, div_signed_o,
           div_annul_o, div_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with divider sequencing.
//   clk   : sole clock, rising edge
//   rst   : synchronous, active-high reset
//   ctrl  : pipe_ctrl_if.slave -- stage stall requests, flush request/target,
//           divider handshake in; per-stage stall vector, flush, divider
//           start/signed/annul, sticky timeout and saturating stall counter out.
module pipe_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 48
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(DIV_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        sgn_q, sgn_nxt;
  logic        to_q, to_set;
  logic        annul;
  logic [5:0]  stall;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sgn_q     <= 1'b0;
      to_q      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sgn_q <= sgn_nxt;
      if (to_set)
        to_q <= 1'b1;
      if (stall != '0 && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sgn_nxt   = sgn_q;
    annul     = 1'b0;
    to_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl.ex_div_req_i && !ctrl.flush_req_i && !ctrl.mem_stallreq_i) begin
          state_nxt = DIV_RUN;
          cnt_nxt   = '0;
          sgn_nxt   = ctrl.ex_div_signed_i;
        end
      end
      DIV_RUN: begin
        cnt_nxt = cnt + 6'd1;
        // Flush beats a ready result; a ready result beats the timeout.
        if (ctrl.flush_req_i) begin
          state_nxt = IDLE;
          annul     = 1'b1;
        end else if (ctrl.div_ready_i) begin
          state_nxt = DIV_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DIV_DONE;
          annul     = 1'b1;
          to_set    = 1'b1;
        end
      end
      DIV_DONE: begin
        // Request line ignored here so the finished divide is not restarted.
        if (ctrl.flush_req_i || !ctrl.mem_stallreq_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = '0;
    if (ctrl.flush_req_i)
      stall = 6'b000000;
    else if (ctrl.mem_stallreq_i)
      stall = 6'b011111;
    else if (ctrl.ex_stallreq_i || state == DIV_RUN ||
             (state == IDLE && ctrl.ex_div_req_i))
      stall = 6'b001111;
    else if (ctrl.id_stallreq_i)
      stall = 6'b000111;
  end

  // Combinational outputs are forced quiet while reset is held.
  assign ctrl.stall_o        = rst ? '0 : stall;
  assign ctrl.flush_o        = !rst && ctrl.flush_req_i;
  assign ctrl.new_pc_o       = (!rst && ctrl.flush_req_i) ? ctrl.new_pc_i : '0;
  assign ctrl.div_start_o    = !rst && state == DIV_RUN;
  assign ctrl.div_signed_o   = !rst && state == DIV_RUN && sgn_q;
  assign ctrl.div_annul_o    = !rst && annul;
  assign ctrl.div_timeout_o  = to_q;
  assign ctrl.stall_cycles_o = stall_cnt;

endmodule
